csr_counter_bank: RTL and testbench
===================================

Name: csr_counter_bank

Overview:
- Parametrised successor to the single cycle/instret CSR counter pair.
- Provides mcycle, minstret and NUM_HPM hardware performance counters (mhpmcounter3..), plus mcountinhibit.
- CSR access is full read/write: csrrw, csrrs and csrrc semantics.
- Sits beside the WB stage. Reads are combinational for the CSR instruction. Writes and increments are registered.

Parameters:
- NUM_HPM, 4, number of event counters (1..29); counter i lives at index 3+i.
- CNT_WIDTH, 64, counter width (33..64). Upper bits above CNT_WIDTH read as zero.
- CYCLE_OFFSET, 4, pipeline compensation subtracted from the cycle value on user-view reads only.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- stall  in  1  pipeline stall (IM or DM); gates instret and hpm increments
- retire  in  1  valid non-NOP instruction retiring in WB
- hpm_event  in  NUM_HPM  per-counter event pulse, counted once per unstalled cycle when high
- csr_addr  in  12  CSR address
- csr_re  in  1  read request (drives csr_illegal checking)
- csr_we  in  1  write request, taken only when stall=0
- csr_op  in  2  01 write, 10 set, 11 clear; 00 means no write
- csr_wdata  in  32  write data / mask
- csr_rdata  out  32  combinational read data
- csr_illegal  out  1  unmapped address, or write to a read-only view
- ovf  out  NUM_HPM+2  sticky wrap flags {hpm[NUM_HPM-1:0], instret, cycle}, cleared by any write to that counter

Behaviour:
- Reset: all counters = 0, mcountinhibit = 0, ovf = 0. Outputs are combinational from state, so csr_rdata = 0 unless a cycle view is addressed (user cycle low reads 0 - CYCLE_OFFSET = 0xFFFFFFFC).
- Address map, low / high halves:
  - User read-only views: cycle C00/C80, instret C02/C82, hpm i at C03+i / C83+i.
  - Machine read/write views: B00/B80, B02/B82, B03+i / B83+i.
  - mcountinhibit: 320. Bit0 = cycle, bit2 = instret, bit 3+i = hpm i. Other bits read 0 and are not writable.
- Read values:
  - User cycle view returns (cycle - CYCLE_OFFSET) mod 2^CNT_WIDTH, split into halves. Machine view returns the raw value.
  - instret and hpm views are raw in both spaces.
  - A read reflects state before any same-cycle write.
- csr_illegal: high when csr_re or csr_we targets an unmapped address, or csr_we with csr_op≠00 targets a C-space address. csr_rdata = 0 on an unmapped address. An illegal write has no effect.
- Write (csr_we=1, csr_op≠00, stall=0, legal):
  - new = wdata (01), old|wdata (10), old&~wdata (11). old is the raw half-value.
  - Only the addressed 32-bit half changes; the other half is kept.
  - For CNT_WIDTH < 64, high-half bits at or above CNT_WIDTH-32 are discarded.
- Increment, per counter, each cycle:
  - cycle: +1 unless inhibited.
  - instret: +1 when retire && !stall && !inhibit.
  - hpm i: +1 when hpm_event[i] && !stall && !inhibit[3+i].
- Collision: a write to a counter (either half) suppresses that counter's increment in the same cycle. The written value appears next cycle; counting resumes the cycle after.
- Wrap: increment from all-ones gives 0 and sets the matching ovf bit. ovf stays set until that counter is written, or rst.
- A write to mcountinhibit takes effect for increments from the next cycle.
- rst mid-operation clears everything immediately (asynchronous), regardless of stall or write.

Test Plan:
- Reset then 10 idle cycles, no inhibit -> read B00 = 10; read C00 = 6; read B80 = 0; csr_illegal = 0.
- retire=1 for 5 cycles with stall high on 2 of them -> B02 = 3; hpm_event[0] pulsed 4 times unstalled -> B03 = 4.
- Collision: write B00 = 0x100 (op 01) while cycle is running -> next-cycle B00 = 0x100, following cycle 0x101. Set op 10 with 0xF on B03 holding 0x10 -> 0x1F. Clear op 11 with 0x3 -> 0x1C.
- Wrap: write B83 = 0xFFFFFFFF and B03 = 0xFFFFFFFF, then one event -> hpm0 = 0, ovf[2] = 1. Write B03 = 0 -> ovf[2] = 0.
- Inhibit: write 320 = 0x5 -> cycle and instret freeze over 8 cycles with retire=1; hpm0 still counts; read 320 = 0x5.
- Illegal: write C00 -> csr_illegal = 1, counter unchanged. Read 0xC1F with NUM_HPM=4 -> csr_illegal = 1, rdata = 0. Assert rst during a write -> all zero next edge.

Source files
------------

// File: rtl/csr_counter_bank.sv
// mcycle/minstret/mhpmcounter bank with mcountinhibit; combinational CSR read, registered write/increment.
// Zero-latency read of pre-write state; writes are dropped while stall is high, increments gated by stall.
module csr_counter_bank #(
   parameter int NUM_HPM      = 4,
   parameter int CNT_WIDTH    = 64,
   parameter int CYCLE_OFFSET = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               retire,
   input  logic [NUM_HPM-1:0] hpm_event,
   input  logic [11:0]        csr_addr,
   input  logic               csr_re,
   input  logic               csr_we,
   input  logic [1:0]         csr_op,
   input  logic [31:0]        csr_wdata,
   output logic [31:0]        csr_rdata,
   output logic               csr_illegal,
   output logic [NUM_HPM+1:0] ovf
);

   // Counter slot order: 0 = cycle, 1 = instret, 2+i = hpm i (same order as ovf).
   localparam int          NC           = NUM_HPM + 2;
   localparam logic [11:0] INHIBIT_ADDR = 12'h320;

   logic [CNT_WIDTH-1:0] cnt_q [NC];
   logic [NC-1:0]        inh_q;
   logic [NC-1:0]        ovf_q;

   logic                 space_u;
   logic                 space_m;
   logic                 hi_half;
   logic [4:0]           idx;
   logic [4:0]           pos;
   logic                 cnt_hit;
   logic                 inh_hit;
   logic                 mapped;
   logic                 wr_req;
   logic                 wr_ok;
   logic                 wr_cnt;
   logic                 wr_inh;
   logic [63:0]          sel_raw;
   logic [CNT_WIDTH-1:0] cyc_user;
   logic [63:0]          rd_full;
   logic [31:0]          cnt_half;
   logic [31:0]          inh_view;
   logic [31:0]          old_half;
   logic [31:0]          new_half;
   logic [63:0]          wr_full;
   logic [CNT_WIDTH-1:0] wr_val;
   logic [NC-1:0]        inc;

   assign space_u = (csr_addr[11:8] == 4'hC);
   assign space_m = (csr_addr[11:8] == 4'hB);
   assign hi_half = csr_addr[7];
   assign idx     = csr_addr[4:0];

   // Index 1 has no counter slot: index 0 maps to slot 0, indices 2.. map to slots 1..
   assign cnt_hit = (space_u || space_m) && (csr_addr[6:5] == 2'b00) &&
                    ((idx == 5'd0) || ((idx >= 5'd2) && ({1'b0, idx} < 6'(NUM_HPM + 3))));
   assign pos     = (idx == 5'd0) ? 5'd0 : idx - 5'd1;
   assign inh_hit = (csr_addr == INHIBIT_ADDR);
   assign mapped  = cnt_hit || inh_hit;

   assign wr_req      = csr_we && (csr_op != 2'b00);
   assign csr_illegal = ((csr_re || csr_we) && !mapped) || (wr_req && space_u);
   assign wr_ok       = wr_req && !stall && !csr_illegal;
   assign wr_cnt      = wr_ok && cnt_hit;
   assign wr_inh      = wr_ok && inh_hit;

   always_comb begin
      sel_raw = '0;
      for (int p = 0; p < NC; p++) begin
         if (pos == 5'(p)) sel_raw = 64'(cnt_q[p]);
      end
   end

   assign cyc_user  = cnt_q[0] - CNT_WIDTH'(CYCLE_OFFSET);
   assign rd_full   = (space_u && (pos == 5'd0)) ? 64'(cyc_user) : sel_raw;
   assign cnt_half  = hi_half ? rd_full[63:32] : rd_full[31:0];
   assign inh_view  = 32'({inh_q[NC-1:1], 1'b0, inh_q[0]});
   assign csr_rdata = inh_hit ? inh_view : (cnt_hit ? cnt_half : 32'h0);

   // Read-modify-write always works on the raw value, never the offset user view.
   assign old_half = inh_hit ? inh_view : (hi_half ? sel_raw[63:32] : sel_raw[31:0]);

   always_comb begin
      new_half = old_half;
      case (csr_op)
         2'b01:   new_half = csr_wdata;
         2'b10:   new_half = old_half | csr_wdata;
         2'b11:   new_half = old_half & ~csr_wdata;
         default: new_half = old_half;
      endcase
   end

   assign wr_full = hi_half ? {new_half, sel_raw[31:0]} : {sel_raw[63:32], new_half};
   assign wr_val  = CNT_WIDTH'(wr_full);

   always_comb begin
      inc    = '0;
      inc[0] = !inh_q[0];
      inc[1] = retire && !stall && !inh_q[1];
      for (int i = 0; i < NUM_HPM; i++) begin
         inc[2+i] = hpm_event[i] && !stall && !inh_q[2+i];
      end
   end

   // A write to either half wins over that counter's increment for the cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NC; p++) cnt_q[p] <= '0;
         inh_q <= '0;
         ovf_q <= '0;
      end else begin
         for (int p = 0; p < NC; p++) begin
            if (wr_cnt && (pos == 5'(p))) begin
               cnt_q[p] <= wr_val;
               ovf_q[p] <= 1'b0;
            end else if (inc[p]) begin
               cnt_q[p] <= cnt_q[p] + CNT_WIDTH'(1);
               if (&cnt_q[p]) ovf_q[p] <= 1'b1;
            end
         end
         if (wr_inh) inh_q <= {new_half[NC:2], new_half[0]};
      end
   end

   assign ovf = ovf_q;

endmodule

// File: tb/tb_csr_counter_bank.sv
// Directed bench for csr_counter_bank (default parameters): reads, RMW ops, collision, wrap, inhibit, illegal, reset.
module tb_csr_counter_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        retire;
   logic [3:0]  hpm_event;
   logic [11:0] csr_addr;
   logic        csr_re;
   logic        csr_we;
   logic [1:0]  csr_op;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic [5:0]  ovf;

   int vectors     = 0;
   int miscompares = 0;

   csr_counter_bank #(
      .NUM_HPM      (4),
      .CNT_WIDTH    (64),
      .CYCLE_OFFSET (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .retire      (retire),
      .hpm_event   (hpm_event),
      .csr_addr    (csr_addr),
      .csr_re      (csr_re),
      .csr_we      (csr_we),
      .csr_op      (csr_op),
      .csr_wdata   (csr_wdata),
      .csr_rdata   (csr_rdata),
      .csr_illegal (csr_illegal),
      .ovf         (ovf)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] exp);
      csr_addr = a;
      csr_re   = 1'b1;
      #1;
      check(tag, csr_rdata, exp);
      csr_re   = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      csr_addr  = a;
      csr_we    = 1'b1;
      csr_op    = op;
      csr_wdata = d;
      @(negedge clk);
      csr_we    = 1'b0;
      csr_op    = 2'b00;
      csr_wdata = 32'h0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; retire = 1'b0; hpm_event = 4'h0;
      csr_addr = 12'h0; csr_re = 1'b0; csr_we = 1'b0; csr_op = 2'b00; csr_wdata = 32'h0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      rd(12'hB00, "rst_mcycle", 32'h0);
      rd(12'hC00, "rst_cycle_user", 32'hFFFF_FFFC);
      rd(12'hC80, "rst_cycleh_user", 32'hFFFF_FFFF);
      check("rst_ovf", 32'(ovf), 32'h0);
      check("rst_illegal", 32'(csr_illegal), 32'h0);

      // Ten free-running cycles
      repeat (10) @(negedge clk);
      rd(12'hB00, "mcycle_10", 32'd10);
      rd(12'hC00, "cycle_user_10", 32'd6);
      rd(12'hB80, "mcycleh_10", 32'd0);
      check("idle_illegal", 32'(csr_illegal), 32'h0);

      // instret with two stalled cycles, then hpm0 events
      for (int j = 0; j < 5; j++) begin
         retire = 1'b1;
         stall  = (j == 1 || j == 3);
         @(negedge clk);
      end
      retire = 1'b0; stall = 1'b0;
      for (int j = 0; j < 4; j++) begin
         hpm_event = 4'b0001; @(negedge clk);
         hpm_event = 4'b0000; @(negedge clk);
      end
      hpm_event = 4'b0001; stall = 1'b1; @(negedge clk);
      hpm_event = 4'b0000; stall = 1'b0;
      rd(12'hB02, "minstret", 32'd3);
      rd(12'hC02, "instret_user", 32'd3);
      rd(12'hB03, "hpm0", 32'd4);
      rd(12'hC03, "hpm0_user", 32'd4);
      rd(12'hB04, "hpm1_idle", 32'd0);

      // Collision with the running cycle counter
      @(negedge clk);
      wr(12'hB00, 2'b01, 32'h100);
      rd(12'hB00, "coll_cycle_wr", 32'h100);
      rd(12'hB80, "coll_cycle_hi", 32'h0);
      @(negedge clk);
      rd(12'hB00, "coll_cycle_next", 32'h101);

      // Collision with an event on hpm0
      hpm_event = 4'b0001;
      wr(12'hB03, 2'b01, 32'h10);
      rd(12'hB03, "coll_hpm_wr", 32'h10);
      @(negedge clk);
      hpm_event = 4'b0000;
      rd(12'hB03, "coll_hpm_next", 32'h11);

      // Set / clear read-modify-write
      @(negedge clk);
      wr(12'hB03, 2'b01, 32'h10);
      csr_addr = 12'hB03; csr_we = 1'b1; csr_op = 2'b10; csr_wdata = 32'hF;
      #1;
      check("read_before_write", csr_rdata, 32'h10);
      @(negedge clk);
      csr_we = 1'b0; csr_op = 2'b00; csr_wdata = 32'h0;
      rd(12'hB03, "set_op", 32'h1F);
      @(negedge clk);
      wr(12'hB03, 2'b11, 32'h3);
      rd(12'hB03, "clear_op", 32'h1C);

      // Half preservation and stalled write
      @(negedge clk);
      wr(12'hB84, 2'b01, 32'h7);
      wr(12'hB04, 2'b01, 32'h9);
      rd(12'hB84, "half_hi_kept", 32'h7);
      rd(12'hB04, "half_lo", 32'h9);
      @(negedge clk);
      stall = 1'b1;
      wr(12'hB04, 2'b01, 32'hAB);
      stall = 1'b0;
      rd(12'hB04, "stalled_write", 32'h9);

      // Wrap of hpm0
      @(negedge clk);
      wr(12'hB83, 2'b01, 32'hFFFF_FFFF);
      wr(12'hB03, 2'b01, 32'hFFFF_FFFF);
      check("pre_wrap_ovf", 32'(ovf), 32'h0);
      hpm_event = 4'b0001; @(negedge clk);
      hpm_event = 4'b0000;
      rd(12'hB03, "wrap_lo", 32'h0);
      rd(12'hB83, "wrap_hi", 32'h0);
      check("wrap_ovf", 32'(ovf), 32'h4);
      @(negedge clk);
      check("ovf_sticky", 32'(ovf), 32'h4);
      wr(12'hB03, 2'b01, 32'h0);
      check("ovf_cleared", 32'(ovf), 32'h0);

      // Inhibit cycle and instret, hpm0 keeps counting
      @(negedge clk);
      wr(12'h320, 2'b01, 32'h5);
      wr(12'hB00, 2'b01, 32'h55);
      rd(12'hB00, "inh_cycle_start", 32'h55);
      retire = 1'b1; hpm_event = 4'b0001;
      repeat (8) @(negedge clk);
      retire = 1'b0; hpm_event = 4'b0000;
      rd(12'hB00, "inh_cycle_frozen", 32'h55);
      rd(12'hB02, "inh_instret_frozen", 32'd3);
      rd(12'hB03, "inh_hpm0_counts", 32'd8);
      rd(12'h320, "mcountinhibit", 32'h5);
      @(negedge clk);
      wr(12'h320, 2'b10, 32'hFFFF_FFFF);
      rd(12'h320, "mcountinhibit_all", 32'h7D);

      // Illegal accesses (all counters frozen here)
      @(negedge clk);
      csr_addr = 12'hC00; csr_we = 1'b1; csr_op = 2'b01; csr_wdata = 32'h1234;
      #1;
      check("illegal_user_write", 32'(csr_illegal), 32'h1);
      @(negedge clk);
      csr_we = 1'b0; csr_op = 2'b00; csr_wdata = 32'h0;
      rd(12'hB00, "illegal_no_effect", 32'h55);
      csr_addr = 12'hC00; csr_we = 1'b1; #1;
      check("user_we_op00_legal", 32'(csr_illegal), 32'h0);
      csr_we = 1'b0;
      @(negedge clk);
      csr_addr = 12'hC1F; csr_re = 1'b1; #1;
      check("unmapped_illegal", 32'(csr_illegal), 32'h1);
      check("unmapped_rdata", csr_rdata, 32'h0);
      csr_addr = 12'hB01; #1;
      check("time_unmapped", 32'(csr_illegal), 32'h1);
      csr_addr = 12'hC07; #1;
      check("past_last_hpm", 32'(csr_illegal), 32'h1);
      csr_addr = 12'hC06; #1;
      check("last_hpm_legal", 32'(csr_illegal), 32'h0);
      csr_re = 1'b0;
      @(negedge clk);

      // Clearing inhibit resumes cycle from the following edge
      wr(12'h320, 2'b11, 32'hFFFF_FFFF);
      rd(12'h320, "inhibit_cleared", 32'h0);
      rd(12'hB00, "resume_same", 32'h55);
      @(negedge clk);
      rd(12'hB00, "resume_next", 32'h56);

      // Asynchronous reset during a write, with a pending ovf
      @(negedge clk);
      wr(12'hB84, 2'b01, 32'hFFFF_FFFF);
      wr(12'hB04, 2'b01, 32'hFFFF_FFFF);
      hpm_event = 4'b0010; @(negedge clk);
      hpm_event = 4'b0000;
      check("hpm1_wrap_ovf", 32'(ovf), 32'h8);
      csr_addr = 12'hB03; csr_we = 1'b1; csr_op = 2'b01; csr_wdata = 32'h77;
      #2 rst = 1'b1;
      #1;
      check("async_rst_ovf", 32'(ovf), 32'h0);
      check("async_rst_hpm0", csr_rdata, 32'h0);
      @(negedge clk);
      csr_we = 1'b0; csr_op = 2'b00; csr_wdata = 32'h0;
      rst = 1'b0;
      rd(12'hB03, "post_rst_hpm0", 32'h0);
      rd(12'hB00, "post_rst_cycle", 32'h0);
      rd(12'h320, "post_rst_inhibit", 32'h0);
      rd(12'hC00, "post_rst_cycle_user", 32'hFFFF_FFFC);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
